alsu_shift_unit: RTL and testbench
==================================

# alsu_shift_unit

Multi-cycle shift/rotate engine that sits directly upstream of the ALSU and produces the `out_shift_reg` operand the ALSU consumes for opcodes 4 (shift) and 5 (rotate). It loads a 6-bit operand on a `start` pulse and performs one single-bit shift or rotate per clock, `amount` times. It then presents the result with a one-cycle `done` pulse. The block removes the need for a combinational barrel shifter in front of the ALSU and gives the ALSU a registered, stable operand.

## Interface
Parameters:
- `WIDTH`, default 6: operand/result width; must match the ALSU `out` width.
- `AMT_W`, default 3: width of `amount`; supports 0..7 single-bit steps.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `start`  in  1: request a new operation; sampled only at a rising edge of `clk`.
- `data_in`  in  WIDTH: operand loaded on an accepted `start`.
- `amount`  in  AMT_W: number of single-bit steps; sampled on an accepted `start`.
- `direction`  in  1: 1 = left, 0 = right; sampled on an accepted `start`.
- `mode`  in  1: 0 = shift, 1 = rotate; sampled on an accepted `start`.
- `serial_in`  in  1: fill bit for shift mode; sampled on an accepted `start` and held for the whole operation.
- `out_shift_reg`  out  WIDTH: working/result register; feeds the ALSU.
- `busy`  out  1: high while the state is SHIFT or DONE.
- `done`  out  1: high for exactly one cycle when `out_shift_reg` holds the final result.
- `start_err`  out  1: sticky flag for a `start` dropped because the block was busy (see Configuration).

## Operation
- States: IDLE, SHIFT, DONE. Registered state, counter `cnt` (AMT_W bits), and captured `dir_q`, `mode_q`, `sin_q`.
- Accepted start: `start`=1 while in IDLE or DONE. On acceptance:
  - `out_shift_reg` ← `data_in`.
  - `cnt` ← `amount`.
  - Control bits are captured.
  - Next state is SHIFT if `amount` ≠ 0, else DONE.
- SHIFT: each edge performs one step and decrements `cnt`. When `cnt` = 1 before the edge, the next state is DONE.
  - Shift left: {`out_shift_reg`[WIDTH-2:0], `sin_q`}.
  - Shift right: {`sin_q`, `out_shift_reg`[WIDTH-1:1]}.
  - Rotate left: {`out_shift_reg`[WIDTH-2:0], `out_shift_reg`[WIDTH-1]}.
  - Rotate right: {`out_shift_reg`[0], `out_shift_reg`[WIDTH-1:1]}.
- DONE: `done`=1 for this one cycle. Next state is IDLE, unless `start` is accepted in this cycle (back-to-back operation).
- `start` in SHIFT is ignored: no reload, and the operation in flight continues unaffected.
- Amount ≥ WIDTH is legal:
  - Shift of 7 yields all bits = `sin_q`.
  - Rotate of 6 returns the original operand.
- `out_shift_reg` holds its value in IDLE and DONE; it changes only on an accepted start or a SHIFT step.

## Timing
- Reset (synchronous, has priority over everything):
  - state IDLE, `cnt`=0, `out_shift_reg`=0, `busy`=0, `done`=0, `start_err`=0.
- Reset in SHIFT or DONE aborts the operation. No `done` is produced, and the result register clears at that edge.
- Let E0 be the edge that accepts `start`:
  - Steps occur at edges E1..EN.
  - `done` is high in the cycle after EN.
  - Latency from the start edge to `done` is N+1 cycles, i.e. N cycles after E0.
  - For `amount`=0, `done` is high in the cycle after E0 and `out_shift_reg`=`data_in`.
- `busy` rises in the cycle after E0 and falls after the DONE cycle, unless a new start is accepted in DONE.
- Sustained throughput: one operation per N+1 cycles when `start` is asserted in every DONE cycle.
- `done` and `busy` are decoded from registered state; there is no combinational path from the inputs.

## Configuration
- Macro `ALSU_SHIFT_START_ERR_EN`.
- Defined:
  - `start_err` is set at any edge where `start`=1 and state = SHIFT.
  - It stays 1 until `reset`.
- Undefined:
  - `start_err` is tied to 0 and no detection logic is built.
  - All other behaviour is identical.

## Test plan
- Shift left: `data_in`=6'b101100, `serial_in`=1, `amount`=2, `mode`=0, `direction`=1.
  - Expect `out_shift_reg`=6'b011001 after E1 and 6'b110011 after E2.
  - Expect `done`=1 only in the cycle after E2.
- Rotate right: `data_in`=6'b000111, `amount`=3, `mode`=1, `direction`=0.
  - Expect 6'b100011, then 6'b110001, then 6'b111000, then `done`.
- Zero amount: `data_in`=6'b010101, `amount`=0.
  - Expect `done`=1 and `out_shift_reg`=6'b010101 in the cycle after E0, with `busy`=1 for exactly one cycle.
- Start during SHIFT: `amount`=5, pulse `start` with `data_in`=6'b111111 at E2.
  - Expect the original result unchanged and `done` after E5.
  - `start_err`=1 with `ALSU_SHIFT_START_ERR_EN` defined, 0 without it.
- Reset mid-operation: `amount`=5, assert `reset` at E2.
  - Expect `out_shift_reg`=0, `busy`=0, `done` never asserted, `start_err`=0.
- Back-to-back: assert `start` (`amount`=1) in the DONE cycle.
  - Expect the new operand loaded at that edge, `busy` to stay high, and the next `done` 2 cycles later.

Source files
------------

// File: rtl/alsu_shift_unit.sv
// Multi-cycle shift/rotate engine producing the registered ALSU shift operand.
// Optional sticky busy-start detection is built when ALSU_SHIFT_START_ERR_EN is defined.
module alsu_shift_unit #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             direction,
    input  logic             mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_shift_reg,
    output logic             busy,
    output logic             done,
    output logic             start_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             dir_q;
    logic             mode_q;
    logic             sin_q;
    logic             busy_q;
    logic             done_q;

    // One single-bit step; rotate recirculates the bit that falls off the end.
    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] v,
        input logic             dir,
        input logic             rot,
        input logic             sin
    );
        logic fill;
        fill = rot ? (dir ? v[WIDTH-1] : v[0]) : sin;
        if (dir) begin
            step_f = {v[WIDTH-2:0], fill};
        end else begin
            step_f = {fill, v[WIDTH-1:1]};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            sin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sr_q   <= data_in;
                        cnt_q  <= amount;
                        dir_q  <= direction;
                        mode_q <= mode;
                        sin_q  <= serial_in;
                        busy_q <= 1'b1;
                        if (amount != '0) begin
                            state_q <= ST_SHIFT;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    sr_q   <= step_f(sr_q, dir_q, mode_q, sin_q);
                    cnt_q  <= cnt_q - AMT_W'(1);
                    busy_q <= 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SHIFT;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALSU_SHIFT_START_ERR_EN
    logic err_q;

    // Sticky: a start that arrives mid-operation is dropped and remembered.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start && (state_q == ST_SHIFT)) begin
            err_q <= 1'b1;
        end
    end

    assign start_err = err_q;
`else
    assign start_err = 1'b0;
`endif

    assign out_shift_reg = sr_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_alsu_shift_unit.sv
// Self-checking bench for alsu_shift_unit: closed-form reference model, per-cycle
// compare, directed scenarios and randomized traffic.
module tb_alsu_shift_unit;

    localparam int W = 6;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [A-1:0] amount = '0;
    logic         direction = 1'b0;
    logic         mode = 1'b0;
    logic         serial_in = 1'b0;
    logic [W-1:0] out_shift_reg;
    logic         busy;
    logic         done;
    logic         start_err;

    int checks = 0;
    int errors = 0;

    alsu_shift_unit #(.WIDTH(W), .AMT_W(A)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .data_in      (data_in),
        .amount       (amount),
        .direction    (direction),
        .mode         (mode),
        .serial_in    (serial_in),
        .out_shift_reg(out_shift_reg),
        .busy         (busy),
        .done         (done),
        .start_err    (start_err)
    );

    always #5 clk = ~clk;

`ifdef ALSU_SHIFT_START_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operand after k steps, written as whole-word arithmetic rather than k iterations.
    function automatic int calc(input int d, input int k, input bit dir, input bit rot, input bit sin);
        int mask;
        int r;
        mask = (1 << W) - 1;
        if (rot) begin
            r = k % W;
            if (dir) return ((d << r) | (d >> (W - r))) & mask;
            else     return ((d >> r) | (d << (W - r))) & mask;
        end
        if (dir) return ((d << k) | (sin ? ((1 << k) - 1) : 0)) & mask;
        return ((d >> k) | (sin ? (mask & ~(mask >> k)) : 0)) & mask;
    endfunction

    // Reference model: 0 idle, 1 stepping, 2 result presented.
    int m_phase = 0;
    int m_k, m_n, m_d;
    bit m_dir, m_rot, m_sin;
    int m_out = 0;
    bit m_err = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_out = 0; m_err = 0; m_valid = 1;
        end else if (m_phase != 1 && start) begin
            m_d = int'(data_in); m_n = int'(amount); m_k = 0;
            m_dir = direction; m_rot = mode; m_sin = serial_in;
            m_out = m_d;
            m_phase = (m_n == 0) ? 2 : 1;
        end else if (m_phase == 1) begin
            if (start && ERR_EN) m_err = 1;
            m_k++;
            m_out = calc(m_d, m_k, m_dir, m_rot, m_sin);
            if (m_k == m_n) m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out", int'(out_shift_reg), m_out);
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("done", int'(done), int'(m_phase == 2));
            chk("start_err", int'(start_err), int'(m_err));
        end
    end

    task automatic launch(input int d, input int a, input bit dir, input bit rot, input bit sin);
        data_in = W'(d); amount = A'(a); direction = dir; mode = rot; serial_in = sin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int n;

    initial begin
        // Pin the model against hand-computed values.
        chk("pin_sl1", calc(6'b101100, 1, 1, 0, 1), 6'b011001);
        chk("pin_sl2", calc(6'b101100, 2, 1, 0, 1), 6'b110011);
        chk("pin_rr1", calc(6'b000111, 1, 0, 1, 0), 6'b100011);
        chk("pin_rr3", calc(6'b000111, 3, 0, 1, 0), 6'b111000);
        chk("pin_sr7", calc(6'b010010, 7, 0, 0, 1), 6'b111111);
        chk("pin_rl6", calc(6'b101101, 6, 1, 1, 0), 6'b101101);

        @(negedge clk);
        do_reset();
        chk("rst_out", int'(out_shift_reg), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(start_err), 0);

        // Shift left by 2 with serial fill 1.
        launch(6'b101100, 2, 1, 0, 1);
        chk("sl_load", int'(out_shift_reg), 6'b101100);
        @(negedge clk);
        chk("sl_e1", int'(out_shift_reg), 6'b011001);
        chk("sl_e1_done", int'(done), 0);
        @(negedge clk);
        chk("sl_e2", int'(out_shift_reg), 6'b110011);
        chk("sl_e2_done", int'(done), 1);
        @(negedge clk);
        chk("sl_after_done", int'(done), 0);
        chk("sl_after_busy", int'(busy), 0);

        // Rotate right by 3.
        launch(6'b000111, 3, 0, 1, 0);
        @(negedge clk);
        chk("rr_e1", int'(out_shift_reg), 6'b100011);
        @(negedge clk);
        chk("rr_e2", int'(out_shift_reg), 6'b110001);
        @(negedge clk);
        chk("rr_e3", int'(out_shift_reg), 6'b111000);
        chk("rr_done", int'(done), 1);
        @(negedge clk);

        // Zero amount: result presented immediately, busy for one cycle.
        launch(6'b010101, 0, 1, 0, 0);
        chk("z_done", int'(done), 1);
        chk("z_out", int'(out_shift_reg), 6'b010101);
        chk("z_busy", int'(busy), 1);
        @(negedge clk);
        chk("z_busy_drop", int'(busy), 0);

        // Start during SHIFT is dropped.
        launch(6'b000011, 5, 1, 0, 0);
        @(negedge clk);
        data_in = 6'b111111; amount = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, n);
        chk("ign_latency", n, 3);
        chk("ign_out", int'(out_shift_reg), 6'b100000);
        chk("ign_err", int'(start_err), int'(ERR_EN));
        @(negedge clk);
        do_reset();
        chk("err_cleared", int'(start_err), 0);

        // Reset at E2 aborts the operation.
        launch(6'b101010, 5, 0, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", int'(out_shift_reg), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(start_err), 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", int'(done), 0);

        // Back-to-back: new start accepted in the DONE cycle.
        launch(6'b000001, 1, 1, 1, 0);
        @(negedge clk);
        chk("b2b_done1", int'(done), 1);
        data_in = 6'b001000; amount = 3'd1; direction = 1'b0; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_load", int'(out_shift_reg), 6'b001000);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_nodone", int'(done), 0);
        @(negedge clk);
        chk("b2b_done2", int'(done), 1);
        chk("b2b_out", int'(out_shift_reg), 6'b000100);
        @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            data_in   = W'($urandom);
            amount    = A'($urandom);
            direction = 1'($urandom);
            mode      = 1'($urandom);
            serial_in = 1'($urandom);
            reset     = ($urandom_range(0, 80) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
